// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the iterative engine.
package aes_pkg;

  localparam int         AES_BLK_W = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Engine FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  // Forward S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One AES round plus the matching on-the-fly key-expansion step.
// With SBOX_REG=1 the S-box outputs are registered, so the next state/key
// outputs are valid one cycle after i_state/i_rkey settle.
module aes_round_unit
  import aes_pkg::*;
#(
  parameter int SBOX_REG = 1
) (
  input  logic                 i_clk,
  input  logic [AES_BLK_W-1:0] i_state,
  input  logic [AES_BLK_W-1:0] i_rkey,
  input  logic [7:0]           i_rcon,
  input  logic                 i_is_final,
  output logic [AES_BLK_W-1:0] o_next_state,
  output logic [AES_BLK_W-1:0] o_next_key
);

  function automatic logic [AES_BLK_W-1:0] sub_bytes(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Bytes are column-major: byte (row + 4*col); row r rotates left by r
  function automatic logic [AES_BLK_W-1:0] shift_rows(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [AES_BLK_W-1:0] mix_columns(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  logic [AES_BLK_W-1:0] w_sub_state;
  logic [AES_BLK_W-1:0] w_shifted;
  logic [31:0]          w_rot_word;
  logic [31:0]          w_sub_word;
  logic [31:0]          w_k0, w_k1, w_k2, w_k3;

  assign w_rot_word = {i_rkey[23:0], i_rkey[31:24]};

  generate
    if (SBOX_REG != 0) begin : g_sbox_reg
      logic [AES_BLK_W-1:0] r_sub_state;
      logic [31:0]          r_sub_word;
      // Register the S-box lookups of the current state and key word every cycle
      // NOTE: no reset here on purpose -- these are pure pipeline registers whose
      // value is only consumed one cycle after being loaded from a reset-clean state.
      always_ff @(posedge i_clk) begin
        r_sub_state <= sub_bytes(i_state);
        r_sub_word  <= sub_word(w_rot_word);
      end
      assign w_sub_state = r_sub_state;
      assign w_sub_word  = r_sub_word;
    end else begin : g_sbox_comb
      logic w_unused_clk;
      assign w_unused_clk = i_clk;
      assign w_sub_state  = sub_bytes(i_state);
      assign w_sub_word   = sub_word(w_rot_word);
    end
  endgenerate

  // Key-expansion step: each word chains from the newly produced previous word
  assign w_k0 = i_rkey[127:96] ^ w_sub_word ^ {i_rcon, 24'h0};
  assign w_k1 = i_rkey[95:64] ^ w_k0;
  assign w_k2 = i_rkey[63:32] ^ w_k1;
  assign w_k3 = i_rkey[31:0]  ^ w_k2;
  assign o_next_key = {w_k0, w_k1, w_k2, w_k3};

  // The final round skips MixColumns
  assign w_shifted    = shift_rows(w_sub_state);
  assign o_next_state = (i_is_final ? w_shifted : mix_columns(w_shifted)) ^ o_next_key;

endmodule

// File: rtl/aes128_iter_engine.sv
// Iterative AES-128 encryption engine: one shared round unit, key expanded on
// the fly, valid/ready streaming on both sides with a tag carried per block.
module aes128_iter_engine
  import aes_pkg::*;
#(
  parameter int NR       = 10,
  parameter int TAG_W    = 8,
  parameter int SBOX_REG = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [AES_BLK_W-1:0] i_in_key,
  input  logic [AES_BLK_W-1:0] i_in_data,
  input  logic [TAG_W-1:0]     i_in_tag,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [AES_BLK_W-1:0] o_out_data,
  output logic [TAG_W-1:0]     o_out_tag,
  output logic                 o_busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  logic [1:0]           r_fsm;
  logic [AES_BLK_W-1:0] r_state;
  logic [AES_BLK_W-1:0] r_rkey;
  logic [TAG_W-1:0]     r_tag;
  logic [7:0]           r_rcon;
  logic [3:0]           r_round;
  logic                 r_phase;
  logic                 r_out_valid;
  logic [AES_BLK_W-1:0] r_out_data;
  logic [TAG_W-1:0]     r_out_tag;

  logic                 w_accept;
  logic                 w_round_step;
  logic                 w_is_final;
  logic [AES_BLK_W-1:0] w_next_state;
  logic [AES_BLK_W-1:0] w_next_key;

  // A new block may enter while idle, or while the finished block is being taken
  assign o_in_ready   = (r_fsm == ST_IDLE) || ((r_fsm == ST_OUT) && i_out_ready);
  assign w_accept     = i_in_valid && o_in_ready;
  assign w_round_step = (SBOX_REG == 0) || r_phase;
  assign w_is_final   = (r_round == LAST_ROUND);

  aes_round_unit #(
    .SBOX_REG (SBOX_REG)
  ) u_round (
    .i_clk        (i_clk),
    .i_state      (r_state),
    .i_rkey       (r_rkey),
    .i_rcon       (r_rcon),
    .i_is_final   (w_is_final),
    .o_next_state (w_next_state),
    .o_next_key   (w_next_key)
  );

  // FSM, round sequencing, output holding and block acceptance
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fsm       <= ST_IDLE;
      r_state     <= '0;
      r_rkey      <= '0;
      r_tag       <= '0;
      r_rcon      <= RCON_INIT;
      r_round     <= '0;
      r_phase     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
        end
        ST_ROUND: begin
          if (w_round_step) begin
            r_state <= w_next_state;
            r_rkey  <= w_next_key;
            r_rcon  <= xtime(r_rcon);
            r_round <= r_round + 4'd1;
            r_phase <= 1'b0;
            if (w_is_final) begin
              r_fsm       <= ST_OUT;
              r_out_valid <= 1'b1;
              r_out_data  <= w_next_state;
              r_out_tag   <= r_tag;
            end
          end else begin
            r_phase <= 1'b1;
          end
        end
        ST_OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_fsm       <= ST_IDLE;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase

      // NOTE: non-blocking assignments let this later block override the OUT->IDLE
      // move above when a new block is taken in the same cycle (last write wins).
      if (w_accept) begin
        r_state <= i_in_data ^ i_in_key;
        r_rkey  <= i_in_key;
        r_tag   <= i_in_tag;
        r_rcon  <= RCON_INIT;
        r_round <= 4'd1;
        r_phase <= 1'b0;
        r_fsm   <= ST_ROUND;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_tag   = r_out_tag;
  assign o_busy      = (r_fsm == ST_ROUND);

endmodule

// File: tb/tb_aes128_iter_engine.sv
// Self-checking bench for aes128_iter_engine: FIPS-197 vectors, handshake
// corner cases and random blocks against a byte-level AES reference model.
module tb_aes128_iter_engine;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_NR1_ZERO = 128'h01000000010000000100000001000000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = '0;
  logic [127:0] pt  = '0;
  logic [7:0]   tag = '0;
  logic         out_ready = 1'b1;
  logic [2:0]   in_valid = '0;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   busy;
  logic [127:0] out_data [3];
  logic [7:0]   out_tag  [3];

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sbox_tab [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: default build; 1: combinational S-box; 2: single round
  aes128_iter_engine #(.NR(10), .TAG_W(8), .SBOX_REG(1)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
    .i_in_key(key), .i_in_data(pt), .i_in_tag(tag), .o_out_valid(out_valid[0]),
    .i_out_ready(out_ready), .o_out_data(out_data[0]), .o_out_tag(out_tag[0]), .o_busy(busy[0]));

  aes128_iter_engine #(.NR(10), .TAG_W(8), .SBOX_REG(0)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
    .i_in_key(key), .i_in_data(pt), .i_in_tag(tag), .o_out_valid(out_valid[1]),
    .i_out_ready(out_ready), .o_out_data(out_data[1]), .o_out_tag(out_tag[1]), .o_busy(busy[1]));

  aes128_iter_engine #(.NR(1), .TAG_W(8), .SBOX_REG(1)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
    .i_in_key(key), .i_in_data(pt), .i_in_tag(tag), .o_out_valid(out_valid[2]),
    .i_out_ready(out_ready), .o_out_data(out_data[2]), .o_out_tag(out_tag[2]), .o_busy(busy[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k_in, input logic [127:0] p_in, input int nr);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] a0, a1, a2, a3, rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = k_in[127-8*i -: 8];
      s[i] = p_in[127-8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row+4*c] = t[row+4*((c+row)%4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      tmp[0] = sbox_tab[k[13]] ^ rc;
      tmp[1] = sbox_tab[k[14]];
      tmp[2] = sbox_tab[k[15]];
      tmp[3] = sbox_tab[k[12]];
      for (int i = 0; i < 4; i++)  k[i] = k[i] ^ tmp[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      rc = gmul(rc, 8'h02);
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Called just after a falling edge; holds valid until the engine is ready
  task automatic issue(input int d, input logic [127:0] k, input logic [127:0] p,
                       input logic [7:0] tg, output int t_acc);
    bit done;
    done  = 1'b0;
    t_acc = -1;
    key = k; pt = p; tag = tg;
    in_valid[d] = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (in_ready[d]) begin
        t_acc = cyc;
        done  = 1'b1;
      end
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    check("accepted", 128'(done), 128'd1);
  endtask

  // Waits for OutValid and checks its cycle offset from acceptance. With
  // scramble set, InValid stays high and inputs keep changing meanwhile.
  task automatic wait_out(input string name, input int d, input int t_acc, input int exp_lat,
                          input bit scramble);
    int lat;
    bit bad;
    lat = -1;
    bad = 1'b0;
    for (int i = 0; i < 64 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid[d]) begin
        lat = cyc - t_acc;
      end else if (scramble) begin
        if (in_ready[d] || !busy[d]) bad = 1'b1;
        in_valid[d] = 1'b1;
        key = rand128();
        pt  = rand128();
        tag = 8'($urandom());
      end
    end
    if (scramble) begin
      in_valid[d] = 1'b0;
      check({name, "_round_ignored_input"}, 128'(bad), 128'd0);
    end
    check({name, "_latency"}, 128'(lat), 128'(exp_lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, c0;
    logic [127:0] k, p, held_d;
    logic [7:0]   tg;
    bit bad;

    build_sbox();

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d_out_valid", d), 128'(out_valid[d]), 128'd0);
      check($sformatf("rst%0d_out_data", d), out_data[d], 128'd0);
      check($sformatf("rst%0d_out_tag", d), 128'(out_tag[d]), 128'd0);
      check($sformatf("rst%0d_busy", d), 128'(busy[d]), 128'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready[0]), 128'd1);

    // FIPS-197 C.1
    issue(0, K_C1, P_C1, 8'hA5, t);
    check("c1_busy", 128'(busy[0]), 128'd1);
    check("c1_round_not_ready", 128'(in_ready[0]), 128'd0);
    wait_out("c1", 0, t, 21, 1'b0);
    check("c1_data", out_data[0], C_C1);
    check("c1_tag", 128'(out_tag[0]), 128'hA5);
    @(negedge clk);
    check("c1_drained", 128'(out_valid[0]), 128'd0);

    // FIPS-197 Appendix B
    issue(0, K_B, P_B, 8'h3C, t);
    wait_out("appb", 0, t, 21, 1'b0);
    check("appb_data", out_data[0], C_B);
    check("appb_tag", 128'(out_tag[0]), 128'h3C);
    @(negedge clk);

    // Backpressure: result held for 50 cycles with competing input offered
    out_ready = 1'b0;
    k = rand128(); p = rand128();
    issue(0, k, p, 8'h77, t);
    wait_out("bp", 0, t, 21, 1'b0);
    check("bp_data", out_data[0], ref_encrypt(k, p, 10));
    held_d = out_data[0];
    bad = 1'b0;
    in_valid[0] = 1'b1;
    repeat (50) begin
      key = rand128(); pt = rand128(); tag = 8'($urandom());
      #1;
      if (in_ready[0]) bad = 1'b1;
      @(negedge clk);
      if (!out_valid[0] || out_data[0] !== held_d || out_tag[0] !== 8'h77) bad = 1'b1;
    end
    check("bp_hold_stable", 128'(bad), 128'd0);
    // Release with a new block offered in the same cycle
    out_ready = 1'b1;
    k = rand128(); p = rand128();
    c0 = cyc;
    issue(0, k, p, 8'h88, t);
    check("bp_same_cycle_accept", 128'(t), 128'(c0));
    check("bp_out_valid_dropped", 128'(out_valid[0]), 128'd0);
    check("bp_second_busy", 128'(busy[0]), 128'd1);
    wait_out("bp2", 0, t, 21, 1'b0);
    check("bp2_data", out_data[0], ref_encrypt(k, p, 10));
    check("bp2_tag", 128'(out_tag[0]), 128'h88);
    @(negedge clk);

    // Reset in the middle of C.1, then Appendix B
    issue(0, K_C1, P_C1, 8'h11, t);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    check("midrst_busy", 128'(busy[0]), 128'd0);
    check("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    check("midrst_out_data", out_data[0], 128'd0);
    issue(0, K_B, P_B, 8'h22, t);
    wait_out("midrst_appb", 0, t, 21, 1'b0);
    check("midrst_appb_data", out_data[0], C_B);
    check("midrst_appb_tag", 128'(out_tag[0]), 128'h22);
    @(negedge clk);

    // InValid held high with changing inputs while rounds run
    out_ready = 1'b0;
    k = rand128(); p = rand128();
    issue(0, k, p, 8'h5A, t);
    wait_out("scr", 0, t, 21, 1'b1);
    check("scr_data", out_data[0], ref_encrypt(k, p, 10));
    check("scr_tag", 128'(out_tag[0]), 128'h5A);
    out_ready = 1'b1;
    @(negedge clk);

    // Random blocks
    for (int i = 0; i < 6; i++) begin
      k = rand128(); p = rand128(); tg = 8'($urandom());
      issue(0, k, p, tg, t);
      wait_out($sformatf("rnd%0d", i), 0, t, 21, 1'b0);
      check($sformatf("rnd%0d_data", i), out_data[0], ref_encrypt(k, p, 10));
      check($sformatf("rnd%0d_tag", i), 128'(out_tag[0]), 128'(tg));
    end
    @(negedge clk);

    // Combinational S-box build
    issue(1, K_C1, P_C1, 8'hC3, t);
    wait_out("comb_c1", 1, t, 11, 1'b0);
    check("comb_c1_data", out_data[1], C_C1);
    check("comb_c1_tag", 128'(out_tag[1]), 128'hC3);
    for (int i = 0; i < 2; i++) begin
      k = rand128(); p = rand128(); tg = 8'($urandom());
      issue(1, k, p, tg, t);
      wait_out($sformatf("comb_rnd%0d", i), 1, t, 11, 1'b0);
      check($sformatf("comb_rnd%0d_data", i), out_data[1], ref_encrypt(k, p, 10));
    end
    @(negedge clk);

    // Single-round build
    issue(2, 128'd0, 128'd0, 8'h01, t);
    wait_out("nr1_zero", 2, t, 3, 1'b0);
    check("nr1_zero_data", out_data[2], C_NR1_ZERO);
    for (int i = 0; i < 2; i++) begin
      k = rand128(); p = rand128(); tg = 8'($urandom());
      issue(2, k, p, tg, t);
      wait_out($sformatf("nr1_rnd%0d", i), 2, t, 3, 1'b0);
      check($sformatf("nr1_rnd%0d_data", i), out_data[2], ref_encrypt(k, p, 1));
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound in case a handshake wedges outside the bounded waits
  initial begin
    #400000;
    $display("FAIL watchdog: cycle %0d reached, limit 40000", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
